// File: rtl/pulse_sync_pkg.sv
// ---------------------------------------------------------------------------
// pulse_sync_pkg
// Shared definitions for the pulse event accumulator:
//   - evt_state_e : report FSM states (IDLE / ACC / SEND)
//   - DEF_*       : default parameter values for pulse_evt_acc
//   - TS_WIDTH    : width of the optional report timestamp
//   - timer_width : width needed by the idle timer to hold FLUSH_TIMEOUT
// ---------------------------------------------------------------------------
package pulse_sync_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,   // accumulator empty, no report pending
      ACC  = 2'd1,   // accumulator non-empty, no report pending
      SEND = 2'd2    // report pending on the output slot
   } evt_state_e;

   localparam int DEF_CNT_WIDTH     = 8;
   localparam int DEF_BATCH_SIZE    = 4;
   localparam int DEF_FLUSH_TIMEOUT = 16;
   localparam int TS_WIDTH          = 16;

   // Bits needed to count 0..ft inclusive (ft is at least 1).
   function automatic int timer_width(input int ft);
      return (ft < 2) ? 1 : $clog2(ft + 1);
   endfunction

endpackage

// File: rtl/pulse_evt_acc_if.sv
// ---------------------------------------------------------------------------
// pulse_evt_acc_if
// Batch report channel (valid/ready) of pulse_evt_acc.
//   cnt_valid : report valid            (master -> slave)
//   cnt_ready : consumer accepts report (slave -> master)
//   cnt_data  : event count of the batch (master -> slave)
//   cnt_ts    : capture timestamp, only with PULSE_EVT_ACC_TIMESTAMP_EN
// Optional feature macro: PULSE_EVT_ACC_TIMESTAMP_EN
// ---------------------------------------------------------------------------
interface pulse_evt_acc_if
   import pulse_sync_pkg::*;
#(
   parameter int CNT_WIDTH = DEF_CNT_WIDTH
);
   logic                 cnt_valid;
   logic                 cnt_ready;
   logic [CNT_WIDTH-1:0] cnt_data;
`ifdef PULSE_EVT_ACC_TIMESTAMP_EN
   logic [TS_WIDTH-1:0]  cnt_ts;

   modport master (output cnt_valid, output cnt_data, output cnt_ts, input cnt_ready);
   modport slave  (input cnt_valid, input cnt_data, input cnt_ts, output cnt_ready);
`else
   modport master (output cnt_valid, output cnt_data, input cnt_ready);
   modport slave  (input cnt_valid, input cnt_data, output cnt_ready);
`endif
endinterface

// File: rtl/pulse_evt_idle_tmr.sv
// ---------------------------------------------------------------------------
// pulse_evt_idle_tmr
// Counts consecutive idle cycles while the accumulator holds events and
// flags a flush timeout once the count reaches FLUSH_TIMEOUT.
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   clear_i       : synchronous clear of the timer
//   load_i        : a report is being loaded this cycle (timer restarts)
//   evt_i         : event this cycle (timer restarts)
//   acc_zero_i    : accumulator is empty (timer held at zero)
//   timeout_o     : idle count saturated and accumulator non-empty
// ---------------------------------------------------------------------------
module pulse_evt_idle_tmr
   import pulse_sync_pkg::*;
#(
   parameter int FLUSH_TIMEOUT = DEF_FLUSH_TIMEOUT
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic clear_i,
   input  logic load_i,
   input  logic evt_i,
   input  logic acc_zero_i,
   output logic timeout_o
);
   localparam int           TW  = timer_width(FLUSH_TIMEOUT);
   localparam logic [TW-1:0] TMO = TW'(FLUSH_TIMEOUT);

   logic [TW-1:0] idle_q;
   logic [TW-1:0] idle_d;

   // Next idle count: restart on activity/empty, otherwise count up and saturate.
   always_comb begin
      idle_d = idle_q;
      if (clear_i || load_i || evt_i || acc_zero_i) begin
         idle_d = {TW{1'b0}};
      end else if (idle_q != TMO) begin
         idle_d = idle_q + TW'(1);
      end else begin
         idle_d = idle_q;
      end
   end

   // Idle count register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         idle_q <= {TW{1'b0}};
      end else begin
         idle_q <= idle_d;
      end
   end

   assign timeout_o = (idle_q == TMO) && !acc_zero_i;

endmodule

// File: rtl/pulse_evt_acc.sv
// ---------------------------------------------------------------------------
// pulse_evt_acc
// Counts event cycles and reports them in batches over a valid/ready slot.
// A report is loaded when the running count reaches BATCH_SIZE or when a
// partial batch has been idle for FLUSH_TIMEOUT cycles. Counting continues
// while a report waits; the accumulator saturates and sets a sticky flag.
// Ports:
//   clk_out  : clock
//   resetn   : asynchronous active-low reset
//   evt_in   : event level, one event per high cycle
//   clear    : synchronous clear of accumulator, idle timer and overflow
//   cnt_if   : report channel (cnt_valid, cnt_ready, cnt_data[, cnt_ts])
//   overflow : sticky saturation flag
// Optional feature macro: PULSE_EVT_ACC_TIMESTAMP_EN adds cnt_ts, the value
// of a free-running 16-bit cycle counter captured with each report.
// ---------------------------------------------------------------------------
module pulse_evt_acc
   import pulse_sync_pkg::*;
#(
   parameter int CNT_WIDTH     = DEF_CNT_WIDTH,
   parameter int BATCH_SIZE    = DEF_BATCH_SIZE,
   parameter int FLUSH_TIMEOUT = DEF_FLUSH_TIMEOUT
) (
   input  logic             clk_out,
   input  logic             resetn,
   input  logic             evt_in,
   input  logic             clear,
   pulse_evt_acc_if.master  cnt_if,
   output logic             overflow
);
   localparam logic [CNT_WIDTH-1:0] ACC_MAX = {CNT_WIDTH{1'b1}};
   localparam logic [CNT_WIDTH-1:0] BATCH   = CNT_WIDTH'(BATCH_SIZE);

   evt_state_e           state_q, state_d;
   logic [CNT_WIDTH-1:0] acc_q, acc_d;
   logic [CNT_WIDTH-1:0] data_q, data_d;
   logic                 valid_q, valid_d;
   logic                 ovf_q, ovf_d;

   logic [CNT_WIDTH-1:0] acc_next_s;
   logic                 sat_try_s;
   logic                 timeout_s;
   logic                 trigger_s;
   logic                 handshake_s;
   logic                 slot_free_s;
   logic                 load_s;

   assign sat_try_s   = evt_in && (acc_q == ACC_MAX);
   assign acc_next_s  = sat_try_s ? acc_q : (acc_q + CNT_WIDTH'(evt_in));
   assign trigger_s   = (acc_next_s >= BATCH) || timeout_s;
   assign handshake_s = valid_q && cnt_if.cnt_ready;
   assign slot_free_s = !valid_q || cnt_if.cnt_ready;
   // clear wins over a trigger in the same cycle: nothing new is loaded.
   assign load_s      = trigger_s && slot_free_s && !clear;

   pulse_evt_idle_tmr #(
      .FLUSH_TIMEOUT (FLUSH_TIMEOUT)
   ) u_idle_tmr (
      .clk_i      (clk_out),
      .rst_ni     (resetn),
      .clear_i    (clear),
      .load_i     (load_s),
      .evt_i      (evt_in),
      .acc_zero_i (acc_q == {CNT_WIDTH{1'b0}}),
      .timeout_o  (timeout_s)
   );

   // Next-state and datapath: accumulator, report slot, overflow, FSM.
   always_comb begin
      state_d = state_q;
      acc_d   = acc_next_s;
      data_d  = data_q;
      ovf_d   = ovf_q | sat_try_s;

      if (clear) begin
         acc_d = {CNT_WIDTH{1'b0}};
         ovf_d = 1'b0;
      end else if (load_s) begin
         acc_d  = {CNT_WIDTH{1'b0}};
         data_d = acc_next_s;
      end else begin
         acc_d = acc_next_s;
      end

      case (state_q)
         IDLE: begin
            if (load_s) begin
               state_d = SEND;
            end else if (acc_d != {CNT_WIDTH{1'b0}}) begin
               state_d = ACC;
            end else begin
               state_d = IDLE;
            end
         end
         ACC: begin
            if (load_s) begin
               state_d = SEND;
            end else if (acc_d == {CNT_WIDTH{1'b0}}) begin
               state_d = IDLE;
            end else begin
               state_d = ACC;
            end
         end
         SEND: begin
            // A pending report only leaves SEND through a handshake;
            // a handshake with a fresh trigger reloads back-to-back.
            if (load_s) begin
               state_d = SEND;
            end else if (handshake_s) begin
               state_d = (acc_d == {CNT_WIDTH{1'b0}}) ? IDLE : ACC;
            end else begin
               state_d = SEND;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      valid_d = (state_d == SEND);
   end

   // State and datapath registers.
   always_ff @(posedge clk_out or negedge resetn) begin
      if (!resetn) begin
         state_q <= IDLE;
         acc_q   <= {CNT_WIDTH{1'b0}};
         data_q  <= {CNT_WIDTH{1'b0}};
         valid_q <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         ovf_q   <= ovf_d;
      end
   end

   assign cnt_if.cnt_valid = valid_q;
   assign cnt_if.cnt_data  = data_q;
   assign overflow         = ovf_q;

`ifdef PULSE_EVT_ACC_TIMESTAMP_EN
   logic [TS_WIDTH-1:0] ts_cnt_q;
   logic [TS_WIDTH-1:0] cnt_ts_q;

   // Free-running cycle counter, sampled into the report alongside cnt_data.
   always_ff @(posedge clk_out or negedge resetn) begin
      if (!resetn) begin
         ts_cnt_q <= {TS_WIDTH{1'b0}};
         cnt_ts_q <= {TS_WIDTH{1'b0}};
      end else begin
         ts_cnt_q <= ts_cnt_q + TS_WIDTH'(1);
         if (load_s) begin
            cnt_ts_q <= ts_cnt_q;
         end else begin
            cnt_ts_q <= cnt_ts_q;
         end
      end
   end

   assign cnt_if.cnt_ts = cnt_ts_q;
`endif

endmodule

// File: tb/tb_pulse_evt_acc.sv
// ---------------------------------------------------------------------------
// tb_pulse_evt_acc
// Self-checking bench for pulse_evt_acc (CNT_WIDTH=4, BATCH_SIZE=4,
// FLUSH_TIMEOUT=3). A behavioural model of the batching rules is advanced
// every clock and compared with the DUT outputs; directed scenarios add
// hand-computed expectations, followed by randomized traffic.
// Optional feature macro: PULSE_EVT_ACC_TIMESTAMP_EN (also checks cnt_ts).
// ---------------------------------------------------------------------------
module tb_pulse_evt_acc;
   localparam int CW   = 4;
   localparam int BS   = 4;
   localparam int FT   = 3;
   localparam int MAXV = 15;

   logic clk_out = 1'b0;
   logic resetn;
   logic evt_in;
   logic clear;
   logic overflow;

   pulse_evt_acc_if #(.CNT_WIDTH(CW)) cnt_if ();

   pulse_evt_acc #(
      .CNT_WIDTH     (CW),
      .BATCH_SIZE    (BS),
      .FLUSH_TIMEOUT (FT)
   ) dut (
      .clk_out  (clk_out),
      .resetn   (resetn),
      .evt_in   (evt_in),
      .clear    (clear),
      .cnt_if   (cnt_if),
      .overflow (overflow)
   );

   always #5 clk_out = ~clk_out;

   int total = 0;
   int bad   = 0;

   // Behavioural model state
   int m_acc, m_idle, m_valid, m_data, m_ovf, m_tsc, m_ts;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_acc = 0; m_idle = 0; m_valid = 0; m_data = 0; m_ovf = 0; m_tsc = 0; m_ts = 0;
   endtask

   // One clock of the batching rules, from the values before the edge.
   task automatic model_step(input int e, input int r, input int c);
      int  an;
      bit  sat, trig, hs, free, load;
      sat  = (e != 0) && (m_acc == MAXV);
      an   = sat ? m_acc : m_acc + e;
      trig = (an >= BS) || ((m_idle == FT) && (m_acc > 0));
      hs   = (m_valid != 0) && (r != 0);
      free = (m_valid == 0) || (r != 0);
      load = trig && free && (c == 0);
      if (load) begin
         m_data = an; m_valid = 1; m_acc = 0; m_idle = 0; m_ts = m_tsc;
      end else begin
         if (hs) m_valid = 0;
         if (c != 0) begin
            m_acc = 0; m_idle = 0;
         end else begin
            if (e != 0 || m_acc == 0) m_idle = 0;
            else if (m_idle < FT)     m_idle = m_idle + 1;
            m_acc = an;
         end
      end
      if (c != 0)  m_ovf = 0;
      else if (sat) m_ovf = 1;
      m_tsc = (m_tsc + 1) % 65536;
   endtask

   // Drive one cycle of inputs, advance model at the edge, compare after it.
   task automatic step(input bit e, input bit r, input bit c);
      evt_in = e; cnt_if.cnt_ready = r; clear = c;
      @(posedge clk_out);
      model_step(e, r, c);
      #1;
      chk("cnt_valid", cnt_if.cnt_valid, m_valid);
      chk("cnt_data",  cnt_if.cnt_data,  m_data);
      chk("overflow",  overflow,         m_ovf);
`ifdef PULSE_EVT_ACC_TIMESTAMP_EN
      chk("cnt_ts",    cnt_if.cnt_ts,    m_ts);
`endif
   endtask

   // Assert reset between edges, check the asynchronous effect, release on a negedge.
   task automatic reset_mid();
      #3 resetn = 1'b0;
      #1;
      model_reset();
      chk("rst_valid", cnt_if.cnt_valid, 0);
      chk("rst_data",  cnt_if.cnt_data,  0);
      chk("rst_ovf",   overflow,         0);
      @(negedge clk_out);
      resetn = 1'b1;
   endtask

   initial begin
      int dens, rdens;
      bit e, r, c;
      resetn = 1'b0; evt_in = 1'b0; clear = 1'b0; cnt_if.cnt_ready = 1'b0;
      model_reset();
      repeat (2) @(posedge clk_out);
      #1;
      chk("init_valid", cnt_if.cnt_valid, 0);
      chk("init_data",  cnt_if.cnt_data,  0);
      chk("init_ovf",   overflow,         0);
      @(negedge clk_out);
      resetn = 1'b1;

      // Batch: four events, ready high -> report of 4 one cycle after the last.
      repeat (3) step(1'b1, 1'b1, 1'b0);
      chk("batch_pre", cnt_if.cnt_valid, 0);
      step(1'b1, 1'b1, 1'b0);
      chk("batch_valid", cnt_if.cnt_valid, 1);
      chk("batch_data",  cnt_if.cnt_data,  4);
      step(1'b0, 1'b1, 1'b0);
      chk("batch_drop", cnt_if.cnt_valid, 0);

      // Timeout: two events, report of 2 after FLUSH_TIMEOUT+2 cycles.
      repeat (2) step(1'b1, 1'b0, 1'b0);
      repeat (3) step(1'b0, 1'b0, 1'b0);
      chk("tmo_early", cnt_if.cnt_valid, 0);
      step(1'b0, 1'b0, 1'b0);
      chk("tmo_valid", cnt_if.cnt_valid, 1);
      chk("tmo_data",  cnt_if.cnt_data,  2);
      step(1'b0, 1'b1, 1'b0);

      // Backpressure and saturation: 20 events with ready low.
      for (int i = 1; i <= 20; i++) begin
         step(1'b1, 1'b0, 1'b0);
         if (i >= 4) chk("bp_hold", cnt_if.cnt_data, 4);
      end
      chk("bp_ovf", overflow, 1);
      step(1'b0, 1'b1, 1'b0);
      chk("sat_valid", cnt_if.cnt_valid, 1);
      chk("sat_data",  cnt_if.cnt_data,  15);
      step(1'b0, 1'b1, 1'b0);
      chk("sat_drop", cnt_if.cnt_valid, 0);
      step(1'b0, 1'b1, 1'b1);
      chk("clr_ovf", overflow, 0);

      // Handshake in the same cycle as the 4th new event: no gap cycle.
      repeat (7) step(1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0);
      chk("b2b_valid", cnt_if.cnt_valid, 1);
      chk("b2b_data",  cnt_if.cnt_data,  4);
      step(1'b0, 1'b1, 1'b0);
      chk("b2b_drop", cnt_if.cnt_valid, 0);

      // Reset mid-SEND, then three events and a clear: no report afterwards.
      repeat (4) step(1'b1, 1'b0, 1'b0);
      chk("send_before_rst", cnt_if.cnt_valid, 1);
      reset_mid();
      repeat (3) step(1'b1, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b1);
      chk("clr_ovf2", overflow, 0);
      for (int i = 0; i < 6; i++) begin
         step(1'b0, 1'b1, 1'b0);
         chk("clr_noreport", cnt_if.cnt_valid, 0);
      end

      // Randomized traffic with changing event / ready densities.
      dens = 50; rdens = 70;
      for (int i = 0; i < 4000; i++) begin
         if (i % 150 == 0) begin
            dens  = $urandom_range(0, 100);
            rdens = $urandom_range(0, 100);
         end
         e = ($urandom_range(0, 99) < dens);
         r = ($urandom_range(0, 99) < rdens);
         c = ($urandom_range(0, 49) == 0);
         step(e, r, c);
         if (i % 900 == 899) reset_mid();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pulse_evt_acc.md
PULSE_EVT_ACC -- requirements
Module: pulse_evt_acc

Interface
REQ-001 SHALL have parameter CNT_WIDTH, default 8: width of the accumulator and of cnt_data.
REQ-002 SHALL have parameter BATCH_SIZE, default 4: event count that triggers a batch report; legal range 1..2^CNT_WIDTH-1.
REQ-003 SHALL have parameter FLUSH_TIMEOUT, default 16: consecutive idle cycles before a partial batch is reported; must be at least 1.
REQ-004 SHALL have port clk_out, input, 1 bit: single clock.
REQ-005 SHALL have port resetn, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port evt_in, input, 1 bit: synchronised event level; each high cycle counts as one event.
REQ-007 SHALL have port clear, input, 1 bit: synchronous clear of the accumulator, the idle timer and overflow.
REQ-008 SHALL have port cnt_valid, output, 1 bit: batch report valid.
REQ-009 SHALL have port cnt_ready, input, 1 bit: consumer accepts the report.
REQ-010 SHALL have port cnt_data, output, CNT_WIDTH bits: event count of the reported batch.
REQ-011 SHALL have port overflow, output, 1 bit: sticky flag, set when the accumulator saturates.

Function
REQ-012 SHALL compute acc_next = acc + evt_in, saturating at 2^CNT_WIDTH-1; when a saturating add is attempted, overflow SHALL be set.
REQ-013 SHALL use idle_cnt as follows:
- cleared to 0 when evt_in=1 or when acc=0;
- otherwise incremented, saturating at FLUSH_TIMEOUT.
REQ-014 SHALL raise trigger when either condition holds:
- batch trigger: acc_next >= BATCH_SIZE;
- timeout trigger: idle_cnt = FLUSH_TIMEOUT and acc > 0.
REQ-015 SHALL treat the output slot as free when cnt_valid=0, or when cnt_valid=1 and cnt_ready=1 in the same cycle.
REQ-016 SHALL, on trigger with the slot free, register cnt_data <= acc_next, set cnt_valid=1, and load acc <= 0 and idle_cnt <= 0 in the same edge.
REQ-017 SHALL have a batch-trigger latency of one cycle: the event in cycle N that completes a batch produces cnt_valid=1 in cycle N+1.
REQ-018 SHALL have a timeout latency such that cnt_valid rises FLUSH_TIMEOUT+2 cycles after the cycle of the last event.
REQ-019 SHALL hold cnt_valid and cnt_data stable until cnt_valid=1 and cnt_ready=1 are sampled together.
REQ-020 SHALL continue accumulating while a report is pending, with no events lost except through saturation.
REQ-021 SHALL implement the FSM states IDLE (acc=0, no report), ACC (acc>0, no report) and SEND (cnt_valid=1), with these transitions:
- IDLE->ACC when evt_in=1 and there is no trigger;
- IDLE->SEND on trigger (possible when BATCH_SIZE=1);
- ACC->SEND on trigger;
- SEND->SEND on handshake plus trigger, giving back-to-back reports;
- SEND->ACC on handshake with acc_next>0 and no trigger;
- SEND->IDLE on handshake with acc_next=0.
REQ-022 SHALL, when clear=1, load acc <= 0, idle_cnt <= 0 and overflow <= 0; clear SHALL NOT drop a pending report; clear SHALL take priority over evt_in and over trigger in the same cycle.
REQ-023 SHALL drive cnt_valid=0 in IDLE and ACC only.

Reset
REQ-024 SHALL, while resetn=0, asynchronously force cnt_valid=0, cnt_data=0, overflow=0, acc=0, idle_cnt=0 and state=IDLE.
REQ-025 SHALL discard a pending report when reset is asserted mid-SEND; there is no replay after reset is released.
REQ-026 SHALL count the first event only in the first clk_out edge after resetn deasserts.

Configuration
REQ-027 SHALL, with PULSE_EVT_ACC_TIMESTAMP_EN defined, add output cnt_ts[15:0]:
- driven from a free-running 16-bit cycle counter, reset to 0, that wraps;
- captured together with cnt_data;
- held with cnt_data and reset to 0.
REQ-028 SHALL, without PULSE_EVT_ACC_TIMESTAMP_EN, have no cnt_ts port and no counter logic.

Structure
REQ-029 SHALL take the state enum (IDLE/ACC/SEND) and the default parameter constants from the shared package pulse_sync_pkg.
REQ-030 SHALL place the idle timer (idle_cnt plus timeout compare) in one sub-module, pulse_evt_idle_tmr.

Verification
All scenarios use CNT_WIDTH=4, BATCH_SIZE=4, FLUSH_TIMEOUT=3 unless stated.
REQ-031 SHALL cover batch: evt_in high in cycles 0..3 with cnt_ready=1 -> cnt_valid=1 in cycle 4, cnt_data=4, cnt_valid=0 in cycle 5.
REQ-032 SHALL cover timeout: evt_in high in cycles 0..1 -> cnt_valid=1 in cycle 6 with cnt_data=2.
REQ-033 SHALL cover backpressure and saturation: cnt_ready=0 with 20 events ->
- cnt_data holds 4 throughout;
- acc saturates at 15 and overflow=1;
- after cnt_ready=1 for one cycle, the next report has cnt_data=15.
REQ-034 SHALL cover simultaneous events: handshake in the same cycle as a 4th new event -> cnt_valid stays 1 and cnt_data updates to 4 with no gap cycle.
REQ-035 SHALL cover reset and clear:
- resetn=0 mid-SEND -> cnt_valid=0 asynchronously;
- after release, 3 events then clear -> no report and overflow=0.
REQ-036 SHALL cover the timestamp build: with PULSE_EVT_ACC_TIMESTAMP_EN, a batch captured at counter value 0xFFFF followed by a batch 2 cycles later -> cnt_ts=0xFFFF, then 0x0001.
